// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM: Moore datapath decode with mem_ready handshake,
// memory-wait timeout, sticky halt/error status and a retired-instruction count.
// Optional single-step input is enabled by defining STEP_EN.
module multicycle_ctrl_v2 #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TMO_W   = 8,
  parameter int unsigned TMO_MAX = 200
) (
  input  logic             clkvar,
  input  logic             rst,
`ifdef STEP_EN
  input  logic             step,
`endif
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             PCWriteCond,
  output logic             PCWriteCondne,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ALUSrcA,
  output logic [2:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IF = 4'b0000, S_ID = 4'b0001, S_MEMADR = 4'b0010, S_LWMEM = 4'b0011,
    S_LWWB = 4'b0100, S_SWMEM = 4'b0101, S_REX = 4'b0110, S_RWB = 4'b0111,
    S_BR = 4'b1000, S_J = 4'b1001, S_IEX = 4'b1010, S_IWB = 4'b1011,
    S_JAL = 4'b1100, S_JR = 4'b1101, S_LUI = 4'b1110, S_IDLE = 4'b1111
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_MAX == 0) ? 0 : TMO_MAX - 1);

  state_t           state_q, state_d, after_st;
  logic [5:0]       opreg, functreg;
  logic             halted_q, halt_req, in_wait, tmo_hit, go;
  logic [1:0]       err_q, halt_code;
  logic [TMO_W-1:0] tmo;
  logic [CNT_W-1:0] retired_q;
  logic             unused_functreg;

  // functreg is latched for the datapath's view of the IR; control itself
  // only needs opreg after ID.
  assign unused_functreg = ^functreg;

`ifdef STEP_EN
  logic step_q;
  always_ff @(posedge clkvar or negedge rst) begin
    if (!rst) step_q <= 1'b0;
    else      step_q <= step;
  end
  assign go = run | (step & ~step_q);
`else
  assign go = run;
`endif

  assign in_wait  = (state_q == S_IF) || (state_q == S_LWMEM) || (state_q == S_SWMEM);
  assign tmo_hit  = (TMO_MAX != 0) && in_wait && !mem_ready && (tmo == TMO_LAST);
  assign after_st = run ? S_IF : S_IDLE;

  always_ff @(posedge clkvar or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      opreg     <= '0;
      functreg  <= '0;
      halted_q  <= 1'b0;
      err_q     <= 2'b00;
      tmo       <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        opreg    <= op;
        functreg <= funct;
      end
      if (halt_req) begin
        halted_q <= 1'b1;
        if (err_q == 2'b00) err_q <= halt_code;
      end
      tmo <= (in_wait && !mem_ready) ? tmo + 1'b1 : '0;
      if (instr_done) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    halt_req  = 1'b0;
    halt_code = 2'b00;
    if (halted_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (go) state_d = S_IF;
        S_IF: begin
          if (mem_ready) state_d = S_ID;
          else if (tmo_hit) begin
            state_d = S_IDLE; halt_req = 1'b1; halt_code = 2'b10;
          end
        end
        // Dispatch uses the live IR; opreg is only valid from the next state on.
        S_ID: begin
          case (op)
            6'b000000: state_d = (funct == 6'b001000) ? S_JR : S_REX;
            6'b100011, 6'b101011: state_d = S_MEMADR;
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: state_d = S_IEX;
            6'b001111: state_d = S_LUI;
            6'b000100, 6'b000101: state_d = S_BR;
            6'b000010: state_d = S_J;
            6'b000011: state_d = S_JAL;
            default: begin
              state_d = S_IDLE; halt_req = 1'b1; halt_code = 2'b01;
            end
          endcase
        end
        S_MEMADR: state_d = (opreg == 6'b100011) ? S_LWMEM : S_SWMEM;
        S_LWMEM: begin
          if (mem_ready) state_d = S_LWWB;
          else if (tmo_hit) begin
            state_d = S_IDLE; halt_req = 1'b1; halt_code = 2'b10;
          end
        end
        S_SWMEM: begin
          if (mem_ready) state_d = after_st;
          else if (tmo_hit) begin
            state_d = S_IDLE; halt_req = 1'b1; halt_code = 2'b10;
          end
        end
        S_REX:  state_d = S_RWB;
        S_IEX:  state_d = S_IWB;
        S_LUI:  state_d = S_IWB;
        S_LWWB, S_RWB, S_BR, S_J, S_IWB, S_JAL, S_JR: state_d = after_st;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // IDLE and HALT share encoding 1111; both decode to all-zero controls.
  always_comb begin
    PCWriteCond = 1'b0; PCWriteCondne = 1'b0; PCWrite = 1'b0; IRWrite = 1'b0;
    RegWrite = 1'b0; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ALUSrcA = 1'b0;
    ALUOp = 3'b000; ALUSrcB = 2'b00; RegDst = 2'b00; MemtoReg = 2'b00;
    PCSource = 2'b00; instr_done = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1; ALUSrcB = 2'b01; PCWrite = mem_ready; IRWrite = mem_ready;
      end
      S_ID:     ALUSrcB = 2'b11;
      S_MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_LWMEM:  begin MemRead = 1'b1; IorD = 1'b1; end
      S_LWWB:   begin RegWrite = 1'b1; MemtoReg = 2'b01; instr_done = 1'b1; end
      S_SWMEM:  begin MemWrite = mem_ready; IorD = 1'b1; instr_done = mem_ready; end
      S_REX:    begin ALUSrcA = 1'b1; ALUOp = 3'b010; end
      S_RWB:    begin RegWrite = 1'b1; RegDst = 2'b01; instr_done = 1'b1; end
      S_BR: begin
        ALUSrcA = 1'b1; ALUOp = 3'b001; PCSource = 2'b01;
        PCWriteCond = ~opreg[0]; PCWriteCondne = opreg[0]; instr_done = 1'b1;
      end
      S_J:      begin PCWrite = 1'b1; PCSource = 2'b10; instr_done = 1'b1; end
      S_IEX:    begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 3'b011; end
      S_IWB:    begin RegWrite = 1'b1; instr_done = 1'b1; end
      S_JAL: begin
        PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1; RegDst = 2'b10;
        MemtoReg = 2'b10; instr_done = 1'b1;
      end
      S_JR:     begin PCWrite = 1'b1; PCSource = 2'b11; instr_done = 1'b1; end
      S_LUI:    begin ALUSrcB = 2'b10; ALUOp = 3'b100; end
      default: ;
    endcase
  end

  assign state    = state_q;
  assign halted   = halted_q;
  assign err_code = err_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed bench for multicycle_ctrl_v2 (TMO_MAX=4): reset, R-type, lw with
// wait states, jal/jr, illegal-op halt, IF timeout, async reset, sw.
module tb_multicycle_ctrl_v2;

  logic        clkvar, rst, run, mem_ready;
  logic [5:0]  op, funct;
  logic        PCWriteCond, PCWriteCondne, PCWrite, IRWrite, RegWrite;
  logic        IorD, MemRead, MemWrite, ALUSrcA;
  logic [2:0]  ALUOp;
  logic [1:0]  ALUSrcB, RegDst, MemtoReg, PCSource, err_code;
  logic [3:0]  state;
  logic        instr_done, halted;
  logic [15:0] retired;
  int          errors = 0;
  int          checks = 0;

  multicycle_ctrl_v2 #(.CNT_W(16), .TMO_W(8), .TMO_MAX(4)) dut (
    .clkvar(clkvar), .rst(rst),
`ifdef STEP_EN
    .step(1'b0),
`endif
    .run(run), .op(op), .funct(funct), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWriteCondne(PCWriteCondne), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSource(PCSource), .state(state),
    .instr_done(instr_done), .halted(halted), .err_code(err_code), .retired(retired)
  );

  initial begin
    clkvar = 1'b0;
    forever #5 clkvar = ~clkvar;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkvar);
    #2;
  endtask

  // {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, PCWriteCond, PCWriteCondne}
  function automatic logic [6:0] ens();
    return {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, PCWriteCond, PCWriteCondne};
  endfunction

  initial begin
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0; op = 6'd0; funct = 6'd0;
    tick(); tick();
    chk("reset_state", 32'(state), 32'hF);
    chk("reset_ens", 32'(ens()), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_err", 32'(err_code), 32'h0);
    chk("reset_retired", 32'(retired), 32'h0);
    rst = 1'b1;
    tick();
    chk("idle_hold", 32'(state), 32'hF);

    // add: IF -> ID -> REX -> RWB
    op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1; run = 1'b1;
    tick(); #1;
    chk("add_if_state", 32'(state), 32'h0);
    chk("add_if_ens", 32'(ens()), 32'b1101000);
    chk("add_if_srcb", 32'(ALUSrcB), 32'h1);
    tick();
    chk("add_id_state", 32'(state), 32'h1);
    chk("add_id_srcb", 32'(ALUSrcB), 32'h3);
    tick();
    chk("add_rex_state", 32'(state), 32'h6);
    chk("add_rex_aluop", 32'({ALUSrcA, ALUOp, ALUSrcB}), 32'b1_010_00);
    tick();
    chk("add_rwb_state", 32'(state), 32'h7);
    chk("add_rwb_ctl", 32'({RegWrite, RegDst, MemtoReg, instr_done}), 32'b1_01_00_1);
    chk("add_rwb_retired", 32'(retired), 32'h0);

    // lw with 3 wait cycles in LWMEM
    op = 6'b100011;
    tick();
    chk("lw_if_state", 32'(state), 32'h0);
    chk("add_retired", 32'(retired), 32'h1);
    tick(); tick();
    chk("lw_memadr", 32'({state, ALUSrcA, ALUSrcB}), 32'b0010_1_10);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("lw_wait_state", 32'(state), 32'h3);
      chk("lw_wait_ctl", 32'({MemRead, IorD, instr_done}), 32'b110);
    end
    mem_ready = 1'b1;
    tick();
    chk("lw_wb", 32'({state, RegWrite, MemtoReg, instr_done}), 32'b0100_1_01_1);
    op = 6'b000011;
    tick();
    chk("lw_done_state", 32'(state), 32'h0);
    chk("lw_retired", 32'(retired), 32'h2);

    // jal then jr
    tick(); tick();
    chk("jal_state", 32'(state), 32'hC);
    chk("jal_ctl", 32'({PCWrite, PCSource, RegWrite, RegDst, MemtoReg, instr_done}),
        32'b1_10_1_10_10_1);
    op = 6'b000000; funct = 6'b001000;
    tick(); tick(); tick();
    chk("jr_state", 32'(state), 32'hD);
    chk("jr_ctl", 32'({PCWrite, PCSource, RegWrite, instr_done}), 32'b1_11_0_1);
    chk("jr_retired_before", 32'(retired), 32'h3);
    run = 1'b0;
    tick();
    chk("jr_to_idle", 32'(state), 32'hF);
    chk("jr_retired", 32'(retired), 32'h4);
    chk("jr_not_halted", 32'(halted), 32'h0);

    // illegal opcode halts and stays halted
    op = 6'b111111; run = 1'b1;
    tick(); tick(); tick();
    chk("ill_state", 32'(state), 32'hF);
    chk("ill_halted", 32'(halted), 32'h1);
    chk("ill_err", 32'(err_code), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ill_stay", 32'({state, halted, ens(), instr_done}), 32'({4'hF, 1'b1, 7'd0, 1'b0}));
    end
    chk("ill_retired", 32'(retired), 32'h4);

    // fetch timeout: 4 wait cycles in IF, no write enables
    rst = 1'b0; #1;
    chk("rst_clear_halt", 32'({halted, err_code}), 32'h0);
    rst = 1'b1; mem_ready = 1'b0; op = 6'b000000; funct = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("tmo_if_state", 32'(state), 32'h0);
      chk("tmo_if_noen", 32'({PCWrite, IRWrite}), 32'h0);
    end
    tick(); #1;
    chk("tmo_state", 32'(state), 32'hF);
    chk("tmo_halted", 32'(halted), 32'h1);
    chk("tmo_err", 32'(err_code), 32'h2);
    chk("tmo_noen", 32'(ens()), 32'h0);

    // one add to bump retired, then async reset in the middle of LWMEM
    rst = 1'b0; #1; rst = 1'b1;
    mem_ready = 1'b1;
    tick(); tick(); tick(); tick();
    op = 6'b100011;
    tick();
    chk("pre_rst_retired", 32'(retired), 32'h1);
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("mid_lw_state", 32'(state), 32'h3);
    #2; rst = 1'b0; #1;
    chk("async_state", 32'(state), 32'hF);
    chk("async_ens", 32'(ens()), 32'h0);
    chk("async_retired", 32'(retired), 32'h0);
    chk("async_err", 32'({halted, err_code}), 32'h0);

    // sw completes on its ready cycle
    @(negedge clkvar); rst = 1'b1; op = 6'b101011; mem_ready = 1'b1; run = 1'b1;
    tick(); tick(); tick(); tick(); #1;
    chk("sw_state", 32'(state), 32'h5);
    chk("sw_ctl", 32'({MemWrite, IorD, MemRead, instr_done}), 32'b1101);
    run = 1'b0;
    tick();
    chk("sw_idle", 32'(state), 32'hF);
    chk("sw_retired", 32'(retired), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
